fast_bypass_queue: RTL

//  Parametrised synchronous FIFO with an optional same-cycle fall-through path.

---
 rtl/fast_bypass_queue_if.sv | 28 ++
 rtl/fast_bypass_queue.sv | 65 ++++++
 2 files changed

// File: rtl/fast_bypass_queue_if.sv
// Write/read handshake bundle for fast_bypass_queue, plus flush and status.
// master drives the producer/consumer side; slave is the queue itself.
interface fast_bypass_queue_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  kill;
    logic                  wready;
    logic                  wvalid;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  rready;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [CW-1:0]         count;
    logic                  afull;

    modport master (
        output kill, wvalid, wdata, rready,
        input  wready, rvalid, rdata, count, afull
    );

    modport slave (
        input  kill, wvalid, wdata, rready,
        output wready, rvalid, rdata, count, afull
    );
endinterface

// File: rtl/fast_bypass_queue.sv
// Synchronous FIFO with full-depth use and an optional same-cycle fall-through
// when empty. Pointers carry one extra wrap bit so full and empty are distinct.
module fast_bypass_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int BYPASS     = 1,
    parameter int AFULL_LVL  = 12
) (
    input logic                clk,
    input logic                rst_n,
    fast_bypass_queue_if.slave q_if
);
    localparam int  AW  = $clog2(DEPTH);
    localparam int  PW  = AW + 1;
    localparam logic BYP = (BYPASS != 0);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wptr_q, wptr_d;
    logic [PW-1:0]         rptr_q, rptr_d;
    logic [PW-1:0]         cnt;
    logic                  empty, full;
    logic                  push, pop, bypass_hit, wr_en;

    assign cnt   = wptr_q - rptr_q;
    assign empty = (cnt == '0);
    assign full  = (cnt == PW'(DEPTH));

    // wready is a pure state function so the read side never reaches the write side.
    assign q_if.wready = ~q_if.kill & ~full;
    assign q_if.rvalid = ~q_if.kill & (~empty | (BYP & q_if.wvalid));
    assign q_if.rdata  = empty ? q_if.wdata : mem_q[rptr_q[AW-1:0]];
    assign q_if.count  = cnt;
    assign q_if.afull  = (cnt >= PW'(AFULL_LVL));

    assign push       = q_if.wvalid & q_if.wready;
    assign pop        = q_if.rready & q_if.rvalid;
    assign bypass_hit = BYP & empty & push & q_if.rready;
    assign wr_en      = push & ~bypass_hit;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (q_if.kill) begin
            rptr_d = wptr_q;
        end else begin
            if (wr_en)         wptr_d = wptr_q + PW'(1);
            if (pop && !empty) rptr_d = rptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q[AW-1:0]] <= q_if.wdata;
    end
endmodule
